// File: rtl/wave_pkg.sv
// Shared definitions for the wave voice scheduler slice.
//   WAVE_NUM_CH_MAX : number of channel slots the hardware can address
//   WAVE_SLOTS      : length of the H_CNT time base
//   WAVE_ADDR_W     : default wave ROM address width
//   alloc_state_e   : allocator FSM states
//   lowest_set()    : index of the lowest set bit of an 8-bit vector (0 when empty)
package wave_pkg;

  localparam int WAVE_NUM_CH_MAX = 8;
  localparam int WAVE_SLOTS      = 16;
  localparam int WAVE_ADDR_W     = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    TRIG = 2'd2,
    GAP  = 2'd3
  } alloc_state_e;

  // Lowest set bit wins; scanning downwards lets the last hit be the lowest index.
  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/wave_lru_age.sv
// Least-recently-triggered tracker used for voice stealing.
// Each channel holds a 3-bit recency rank: a touched channel becomes 7 and every
// channel ranked above its old rank moves down by one. Ranks clear to 0 at reset,
// so untouched channels tie at the bottom and the lowest index among them wins.
// Ports:
//   I_CLK, I_RSTn   clock, asynchronous active-low reset
//   I_TOUCH         a trigger happened this cycle
//   I_TOUCH_CHAN    channel that was triggered
//   I_ELIG          channels that may be chosen
//   O_OLDEST        eligible channel with the lowest rank
//   O_OLDEST_VLD    at least one channel is eligible
module wave_lru_age
  import wave_pkg::*;
(
  input  logic       I_CLK,
  input  logic       I_RSTn,
  input  logic       I_TOUCH,
  input  logic [2:0] I_TOUCH_CHAN,
  input  logic [7:0] I_ELIG,
  output logic [2:0] O_OLDEST,
  output logic       O_OLDEST_VLD
);

  logic [2:0] rank_r [WAVE_NUM_CH_MAX];
  logic [2:0] best_s;

  // Rank update on every trigger.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      for (int c = 0; c < WAVE_NUM_CH_MAX; c++) rank_r[c] <= 3'd0;
    end else if (I_TOUCH) begin
      for (int c = 0; c < WAVE_NUM_CH_MAX; c++) begin
        if (3'(c) == I_TOUCH_CHAN) begin
          rank_r[c] <= 3'd7;
        end else if (rank_r[c] > rank_r[I_TOUCH_CHAN]) begin
          rank_r[c] <= rank_r[c] - 3'd1;
        end else begin
          rank_r[c] <= rank_r[c];
        end
      end
    end else begin
      for (int c = 0; c < WAVE_NUM_CH_MAX; c++) rank_r[c] <= rank_r[c];
    end
  end

  // Oldest eligible channel; strict compare keeps the lowest index on ties.
  always_comb begin
    best_s       = 3'd7;
    O_OLDEST     = 3'd0;
    O_OLDEST_VLD = 1'b0;
    for (int c = 0; c < WAVE_NUM_CH_MAX; c++) begin
      if (I_ELIG[c] && (!O_OLDEST_VLD || (rank_r[c] < best_s))) begin
        O_OLDEST_VLD = 1'b1;
        O_OLDEST     = 3'(c);
        best_s       = rank_r[c];
      end else begin
        best_s = best_s;
      end
    end
  end

endmodule

// File: rtl/wave_voice_sched.sv
// Voice scheduler and wave-ROM arbiter for up to 8 wave players sharing one ROM.
// Generates the 16-slot H_CNT time base, time-multiplexes each channel's ROM
// address into its slot, allocates channels for play requests and issues the
// per-channel DMA trigger and stop controls.
// Build option: WAVE_SCHED_STEAL_EN -- when no channel is free, steal the
// least-recently-triggered non-pending channel instead of stalling.
// Ports:
//   I_CLK, I_RSTn          clock, asynchronous active-low reset
//   O_H_CNT                free-running slot counter
//   I_CH_ADDR/I_CH_ACTIVE  per-channel ROM address and playing flag
//   O_ROM_ADDR/I_ROM_DATA  wave ROM interface; O_CH_DATA is ROM data broadcast
//   I_PLAY_VLD/O_PLAY_RDY  play request handshake, I_PLAY_ADDR start address
//   O_PLAY_CHAN            channel given to the last accepted request
//   I_STOP_REQ/ALL/CHAN    stop command
//   O_DMA_TRIG/ADDR/STOP   per-channel trigger pulse, start address, stop level
module wave_voice_sched
  import wave_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int ADDR_W  = WAVE_ADDR_W,
  parameter int ROM_LAT = 1,
  parameter int STOP_TO = 255
) (
  input  logic                                I_CLK,
  input  logic                                I_RSTn,
  output logic [3:0]                          O_H_CNT,
  input  logic [WAVE_NUM_CH_MAX*ADDR_W-1:0]   I_CH_ADDR,
  input  logic [7:0]                          I_CH_ACTIVE,
  output logic [ADDR_W-1:0]                   O_ROM_ADDR,
  input  logic [7:0]                          I_ROM_DATA,
  output logic [7:0]                          O_CH_DATA,
  input  logic                                I_PLAY_VLD,
  output logic                                O_PLAY_RDY,
  input  logic [ADDR_W-1:0]                   I_PLAY_ADDR,
  output logic [2:0]                          O_PLAY_CHAN,
  input  logic                                I_STOP_REQ,
  input  logic                                I_STOP_ALL,
  input  logic [2:0]                          I_STOP_CHAN,
  output logic [7:0]                          O_DMA_TRIG,
  output logic [ADDR_W-1:0]                   O_DMA_ADDR,
  output logic [7:0]                          O_DMA_STOP
);

  localparam int         STOP_W  = $clog2(STOP_TO + 1);
  localparam logic [7:0] CH_MASK = 8'((9'd1 << NUM_CH) - 9'd1);

  alloc_state_e        state_r, state_nxt_s;
  logic [3:0]          h_cnt_r;
  logic [4:0]          slot_sum_s;
  logic [2:0]          rom_ch_s;
  logic [ADDR_W-1:0]   rom_addr_r, rom_addr_d_s;
  logic [7:0]          act_prev_r, act_rise_s;
  logic [7:0]          pend_r, stop_r, free_s, stop_cmd_s;
  logic [2:0]          pend_cnt_r [WAVE_NUM_CH_MAX];
  logic [STOP_W-1:0]   stop_cnt_r [WAVE_NUM_CH_MAX];
  logic                pick_ok_s;
  logic [2:0]          pick_chan_s;
  logic [7:0]          trig_r, trig_d_s;
  logic                rdy_r, rdy_d_s;
  logic [2:0]          chan_r, chan_d_s;
  logic [ADDR_W-1:0]   dma_addr_r, dma_addr_d_s;

  assign O_H_CNT     = h_cnt_r;
  assign O_ROM_ADDR  = rom_addr_r;
  assign O_CH_DATA   = I_ROM_DATA;
  assign O_PLAY_RDY  = rdy_r;
  assign O_PLAY_CHAN = chan_r;
  assign O_DMA_TRIG  = trig_r;
  assign O_DMA_ADDR  = dma_addr_r;
  assign O_DMA_STOP  = stop_r;

  // Address for the slot that starts next cycle: ROM_LAT clocks ahead of the
  // data slot {c,1}, so channel = (next H_CNT + ROM_LAT) mod 16 >> 1.
  always_comb begin
    slot_sum_s = {1'b0, h_cnt_r + 4'd1} + 5'(ROM_LAT);
    rom_ch_s   = slot_sum_s[3:1];
    if (int'(rom_ch_s) < NUM_CH) begin
      rom_addr_d_s = I_CH_ADDR[rom_ch_s*ADDR_W +: ADDR_W];
    end else begin
      rom_addr_d_s = '0;
    end
  end

  // Slot counter and registered ROM address.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      h_cnt_r    <= 4'd0;
      rom_addr_r <= '0;
    end else begin
      h_cnt_r    <= h_cnt_r + 4'd1;
      rom_addr_r <= rom_addr_d_s;
    end
  end

  // Stop command decode, plus the edge detect used to retire pending channels.
  always_comb begin
    act_rise_s = I_CH_ACTIVE & ~act_prev_r;
    free_s     = ~I_CH_ACTIVE & ~pend_r & CH_MASK;
    if (!I_STOP_REQ) begin
      stop_cmd_s = 8'd0;
    end else if (I_STOP_ALL) begin
      stop_cmd_s = CH_MASK;
    end else begin
      stop_cmd_s = (8'd1 << I_STOP_CHAN) & CH_MASK;
    end
  end

  // Pending and stop bookkeeping per channel; a trigger overrides any stop.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      act_prev_r <= 8'd0;
      pend_r     <= 8'd0;
      stop_r     <= 8'd0;
      for (int c = 0; c < WAVE_NUM_CH_MAX; c++) begin
        pend_cnt_r[c] <= 3'd0;
        stop_cnt_r[c] <= '0;
      end
    end else begin
      act_prev_r <= I_CH_ACTIVE;
      for (int c = 0; c < WAVE_NUM_CH_MAX; c++) begin
        if (trig_r[c]) begin
          pend_r[c]     <= 1'b1;
          pend_cnt_r[c] <= 3'd0;
        end else if (pend_r[c] && (act_rise_s[c] || (pend_cnt_r[c] == 3'd7))) begin
          pend_r[c]     <= 1'b0;
        end else if (pend_r[c]) begin
          pend_cnt_r[c] <= pend_cnt_r[c] + 3'd1;
        end else begin
          pend_r[c]     <= 1'b0;
        end

        if (trig_r[c]) begin
          stop_r[c]     <= 1'b0;
        end else if (stop_cmd_s[c]) begin
          stop_r[c]     <= 1'b1;
          stop_cnt_r[c] <= '0;
        end else if (stop_r[c] && (!I_CH_ACTIVE[c] || (stop_cnt_r[c] == STOP_W'(STOP_TO - 1)))) begin
          stop_r[c]     <= 1'b0;
        end else if (stop_r[c]) begin
          stop_cnt_r[c] <= stop_cnt_r[c] + 1'b1;
        end else begin
          stop_r[c]     <= 1'b0;
        end
      end
    end
  end

`ifdef WAVE_SCHED_STEAL_EN
  logic [2:0] lru_chan_s;
  logic       lru_vld_s;

  wave_lru_age u_lru (
    .I_CLK        (I_CLK),
    .I_RSTn       (I_RSTn),
    .I_TOUCH      (|trig_r),
    .I_TOUCH_CHAN (chan_r),
    .I_ELIG       (CH_MASK & ~pend_r),
    .O_OLDEST     (lru_chan_s),
    .O_OLDEST_VLD (lru_vld_s)
  );

  // Free channel first; otherwise steal the oldest non-pending channel.
  always_comb begin
    if (|free_s) begin
      pick_ok_s   = 1'b1;
      pick_chan_s = lowest_set(free_s);
    end else if (lru_vld_s) begin
      pick_ok_s   = 1'b1;
      pick_chan_s = lru_chan_s;
    end else begin
      pick_ok_s   = 1'b0;
      pick_chan_s = 3'd0;
    end
  end
`else
  // Only genuinely free channels can be allocated.
  always_comb begin
    pick_ok_s   = |free_s;
    pick_chan_s = lowest_set(free_s);
  end
`endif

  // Allocator state register.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Allocator next state; GAP keeps back-to-back triggers separated by a low clock.
  always_comb begin
    case (state_r)
      IDLE:    state_nxt_s = I_PLAY_VLD ? PICK : IDLE;
      PICK:    state_nxt_s = pick_ok_s ? TRIG : PICK;
      TRIG:    state_nxt_s = GAP;
      GAP:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register into the TRIG cycle.
  always_comb begin
    trig_d_s     = 8'd0;
    rdy_d_s      = 1'b0;
    chan_d_s     = chan_r;
    dma_addr_d_s = dma_addr_r;
    if (state_nxt_s == TRIG) begin
      trig_d_s     = 8'd1 << pick_chan_s;
      rdy_d_s      = 1'b1;
      chan_d_s     = pick_chan_s;
      dma_addr_d_s = I_PLAY_ADDR;
    end else begin
      rdy_d_s      = 1'b0;
    end
  end

  // Allocator output registers.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      trig_r     <= 8'd0;
      rdy_r      <= 1'b0;
      chan_r     <= 3'd0;
      dma_addr_r <= '0;
    end else begin
      trig_r     <= trig_d_s;
      rdy_r      <= rdy_d_s;
      chan_r     <= chan_d_s;
      dma_addr_r <= dma_addr_d_s;
    end
  end

endmodule
